// File: rtl/opb_bus_arbiter.sv
// Round-robin OPB arbiter: grants one master at a time, muxes its bus onto the OPB,
// gates slave handshakes back to the masters and enforces a transfer timeout.
// Buses use descending ranges; OPB bit 0 (MSB) corresponds to index [31] here.
module opb_bus_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    input  logic [NUM_MASTERS-1:0]      M_request,
    input  logic [NUM_MASTERS-1:0]      M_busLock,
    input  logic [NUM_MASTERS-1:0]      M_select,
    input  logic [NUM_MASTERS-1:0]      M_RNW,
    input  logic [NUM_MASTERS-1:0]      M_seqAddr,
    input  logic [32*NUM_MASTERS-1:0]   M_ABus,
    input  logic [4*NUM_MASTERS-1:0]    M_BE,
    input  logic [32*NUM_MASTERS-1:0]   M_DBus,
    output logic [NUM_MASTERS-1:0]      OPB_MGrant,
    output logic [31:0]                 OPB_ABus,
    output logic [3:0]                  OPB_BE,
    output logic [31:0]                 OPB_DBus,
    output logic                        OPB_RNW,
    output logic                        OPB_select,
    output logic                        OPB_seqAddr,
    input  logic [31:0]                 Sl_DBus,
    input  logic                        Sl_xferAck,
    input  logic                        Sl_errAck,
    input  logic                        Sl_retry,
    input  logic                        Sl_toutSup,
    output logic                        OPB_xferAck,
    output logic                        OPB_errAck,
    output logic                        OPB_retry,
    output logic [31:0]                 OPB_rdDBus,
    output logic                        OPB_timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]         gidx_q, gidx_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     pick_valid;
    logic [IDX_W-1:0]         pick_idx;
    logic [IDX_W-1:0]         cand;
    logic                     in_xfer;

    // State, grant, round-robin pointer and timeout counter
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_LAST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // First requester searching from last+1 with wrap-around
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            cand = IDX_W'((32'(last_q) + i) % NUM_MASTERS);
            if (!pick_valid && M_request[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        OPB_timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    gidx_d            = pick_idx;
                    state_d           = GRANT;
                end
            end
            GRANT: begin
                if (M_select[gidx_q]) begin
                    state_d = XFER;
                    cnt_d   = '0;
                end else if (!M_request[gidx_q] && !M_busLock[gidx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end
            end
            XFER: begin
                if (Sl_xferAck || Sl_errAck) begin
                    cnt_d = '0;
                    if (M_seqAddr[gidx_q] || M_busLock[gidx_q]) begin
                        if (!M_select[gidx_q]) state_d = GRANT;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        last_d  = gidx_q;
                    end
                end else if (Sl_retry) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = gidx_q;
                end else if (cnt_q == CNT_LAST) begin
                    OPB_timeout = 1'b1;
                    state_d     = IDLE;
                    grant_d     = '0;
                    last_d      = gidx_q;
                end else if (!M_select[gidx_q]) begin
                    if (M_busLock[gidx_q]) begin
                        state_d = GRANT;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        last_d  = gidx_q;
                    end
                end else if (!Sl_toutSup) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // AND-OR mux of the granted master; all zero when nobody holds the grant
    always_comb begin
        OPB_ABus    = '0;
        OPB_BE      = '0;
        OPB_DBus    = '0;
        OPB_RNW     = 1'b0;
        OPB_select  = 1'b0;
        OPB_seqAddr = 1'b0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            OPB_ABus    = OPB_ABus | (M_ABus[32*i +: 32] & {32{grant_q[i]}});
            OPB_BE      = OPB_BE   | (M_BE[4*i +: 4]    & {4{grant_q[i]}});
            OPB_DBus    = OPB_DBus | (M_DBus[32*i +: 32] & {32{grant_q[i]}});
            OPB_RNW     = OPB_RNW     | (M_RNW[i]     & grant_q[i]);
            OPB_select  = OPB_select  | (M_select[i]  & grant_q[i]);
            OPB_seqAddr = OPB_seqAddr | (M_seqAddr[i] & grant_q[i]);
        end
    end

    assign in_xfer     = (state_q == XFER);
    assign OPB_MGrant  = grant_q;
    assign OPB_xferAck = in_xfer & Sl_xferAck;
    assign OPB_errAck  = in_xfer & Sl_errAck;
    assign OPB_retry   = in_xfer & Sl_retry;
    assign OPB_rdDBus  = OPB_xferAck ? Sl_DBus : 32'h0;

endmodule

// File: tb/tb_opb_bus_arbiter.sv
// Directed bench for opb_bus_arbiter: a cycle table for basic and alternating transfers,
// then hand sequences for bus lock, timeout, retry and asynchronous reset.
module tb_opb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_request, m_lock, m_select, m_seq;
    logic [1:0]  m_rnw  = 2'b01;
    logic [63:0] m_abus = {32'h01088300, 32'h01088200};
    logic [7:0]  m_be   = {4'hC, 4'hF};
    logic [63:0] m_dbus = {32'h11112222, 32'h33334444};
    logic [1:0]  grant;
    logic [31:0] opb_abus, opb_dbus, opb_rd, sl_dbus;
    logic [3:0]  opb_be;
    logic        opb_rnw, opb_select, opb_seq;
    logic        sl_xack, sl_err, sl_retry, sl_tsup;
    logic        opb_xack, opb_err, opb_retry, opb_tout;

    int n_pass  = 0;
    int n_total = 0;
    int pulses;

    localparam logic [31:0] A0 = 32'h01088200;
    localparam logic [31:0] A1 = 32'h01088300;

    always #5 clk = ~clk;

    opb_bus_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(16)) dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n),
        .M_request(m_request), .M_busLock(m_lock), .M_select(m_select),
        .M_RNW(m_rnw), .M_seqAddr(m_seq), .M_ABus(m_abus), .M_BE(m_be), .M_DBus(m_dbus),
        .OPB_MGrant(grant), .OPB_ABus(opb_abus), .OPB_BE(opb_be), .OPB_DBus(opb_dbus),
        .OPB_RNW(opb_rnw), .OPB_select(opb_select), .OPB_seqAddr(opb_seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(sl_xack), .Sl_errAck(sl_err), .Sl_retry(sl_retry),
        .Sl_toutSup(sl_tsup), .OPB_xferAck(opb_xack), .OPB_errAck(opb_err),
        .OPB_retry(opb_retry), .OPB_rdDBus(opb_rd), .OPB_timeout(opb_tout)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  sel;
        logic        xack;
        logic [31:0] sdat;
        logic [1:0]  e_grant;
        logic        e_sel;
        logic [31:0] e_abus;
        logic        e_rnw;
        logic        e_xack;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [1:0] req, input logic [1:0] sel, input logic xack,
                               input logic [31:0] sdat, input logic [1:0] e_grant,
                               input logic e_sel, input logic [31:0] e_abus, input logic e_rnw,
                               input logic e_xack, input logic [31:0] e_rd);
        vec_t r;
        r.req = req; r.sel = sel; r.xack = xack; r.sdat = sdat;
        r.e_grant = e_grant; r.e_sel = e_sel; r.e_abus = e_abus; r.e_rnw = e_rnw;
        r.e_xack = e_xack; r.e_rd = e_rd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else n_pass++;
    endtask

    // Drive all master/slave controls, then let combinational outputs settle
    task automatic set_in(input logic [1:0] req, input logic [1:0] sel, input logic [1:0] lock,
                          input logic [1:0] seq, input logic xack, input logic err,
                          input logic retry, input logic tsup);
        m_request = req; m_select = sel; m_lock = lock; m_seq = seq;
        sl_xack = xack; sl_err = err; sl_retry = retry; sl_tsup = tsup;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        sl_dbus = 32'h0;
        set_in(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_grant",  32'(grant), 32'h0);
        chk("reset_select", 32'(opb_select), 32'h0);
        chk("reset_abus",   opb_abus, 32'h0);
        chk("reset_tout",   32'(opb_tout), 32'h0);

        // Single read, then two masters alternating
        tbl.push_back(v(2'b01, 2'b00, 0, 32'h0,      2'b00, 0, 32'h0, 0, 0, 32'h0));
        tbl.push_back(v(2'b01, 2'b01, 1, 32'hDEAD,   2'b01, 1, A0,    1, 0, 32'h0));
        tbl.push_back(v(2'b01, 2'b01, 0, 32'h0,      2'b01, 1, A0,    1, 0, 32'h0));
        tbl.push_back(v(2'b00, 2'b01, 1, 32'h2A,     2'b01, 1, A0,    1, 1, 32'h2A));
        tbl.push_back(v(2'b00, 2'b00, 1, 32'h2A,     2'b00, 0, 32'h0, 0, 0, 32'h0));
        tbl.push_back(v(2'b00, 2'b00, 0, 32'h0,      2'b00, 0, 32'h0, 0, 0, 32'h0));
        tbl.push_back(v(2'b11, 2'b00, 0, 32'h0,      2'b00, 0, 32'h0, 0, 0, 32'h0));
        tbl.push_back(v(2'b11, 2'b10, 0, 32'h0,      2'b10, 1, A1,    0, 0, 32'h0));
        tbl.push_back(v(2'b11, 2'b10, 1, 32'h5,      2'b10, 1, A1,    0, 1, 32'h5));
        tbl.push_back(v(2'b11, 2'b00, 0, 32'h0,      2'b00, 0, 32'h0, 0, 0, 32'h0));
        tbl.push_back(v(2'b11, 2'b01, 0, 32'h0,      2'b01, 1, A0,    1, 0, 32'h0));
        tbl.push_back(v(2'b11, 2'b01, 1, 32'h6,      2'b01, 1, A0,    1, 1, 32'h6));
        tbl.push_back(v(2'b11, 2'b00, 0, 32'h0,      2'b00, 0, 32'h0, 0, 0, 32'h0));
        tbl.push_back(v(2'b11, 2'b10, 0, 32'h0,      2'b10, 1, A1,    0, 0, 32'h0));
        tbl.push_back(v(2'b11, 2'b10, 1, 32'h7,      2'b10, 1, A1,    0, 1, 32'h7));
        tbl.push_back(v(2'b11, 2'b00, 0, 32'h0,      2'b00, 0, 32'h0, 0, 0, 32'h0));
        tbl.push_back(v(2'b00, 2'b00, 0, 32'h0,      2'b01, 0, A0,    1, 0, 32'h0));
        tbl.push_back(v(2'b00, 2'b00, 0, 32'h0,      2'b00, 0, 32'h0, 0, 0, 32'h0));

        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            sl_dbus = tbl[i].sdat;
            set_in(tbl[i].req, tbl[i].sel, 2'b00, 2'b00, tbl[i].xack, 1'b0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_grant", i), 32'(grant),      32'(tbl[i].e_grant));
            chk($sformatf("tbl%0d_sel", i),   32'(opb_select), 32'(tbl[i].e_sel));
            chk($sformatf("tbl%0d_abus", i),  opb_abus,        tbl[i].e_abus);
            chk($sformatf("tbl%0d_rnw", i),   32'(opb_rnw),    32'(tbl[i].e_rnw));
            chk($sformatf("tbl%0d_xack", i),  32'(opb_xack),   32'(tbl[i].e_xack));
            chk($sformatf("tbl%0d_rd", i),    opb_rd,          tbl[i].e_rd);
            @(negedge clk);
        end
        sl_dbus = 32'h0;

        // Bus lock: master 0 keeps the grant over three acks while master 1 waits
        set_in(2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0); @(negedge clk);
        set_in(2'b11, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0);
        chk("lock_grant0", 32'(grant), 32'h1); @(negedge clk);
        set_in(2'b11, 2'b01, 2'b01, 2'b00, 1, 0, 0, 0);
        chk("lock_ack1", 32'(opb_xack), 32'h1); @(negedge clk);
        set_in(2'b11, 2'b01, 2'b01, 2'b00, 0, 1, 0, 0);
        chk("lock_grant2", 32'(grant), 32'h1);
        chk("lock_err2", 32'(opb_err), 32'h1); @(negedge clk);
        set_in(2'b11, 2'b01, 2'b00, 2'b00, 1, 0, 0, 0);
        chk("lock_grant3", 32'(grant), 32'h1); @(negedge clk);
        set_in(2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("lock_dead", 32'(grant), 32'h0); @(negedge clk);
        set_in(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("lock_m1", 32'(grant), 32'h2); @(negedge clk);
        set_in(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("lock_rel", 32'(grant), 32'h0); @(negedge clk);

        // Timeout: 16th XFER cycle without ack pulses OPB_timeout once
        set_in(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0); @(negedge clk);
        set_in(2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("tout_grant", 32'(grant), 32'h1); @(negedge clk);
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            set_in(2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
            if (opb_tout) pulses++;
            chk($sformatf("tout_cyc%0d", k), 32'(opb_tout), (k == 16) ? 32'h1 : 32'h0);
            @(negedge clk);
        end
        set_in(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("tout_pulses", 32'(pulses), 32'h1);
        chk("tout_drop", 32'(grant), 32'h0);
        chk("tout_after", 32'(opb_tout), 32'h0); @(negedge clk);

        // Timeout suppressed for 20 cycles, then acked
        set_in(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1); @(negedge clk);
        set_in(2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 1); @(negedge clk);
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            set_in(2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 1);
            if (opb_tout) pulses++;
            @(negedge clk);
        end
        set_in(2'b00, 2'b01, 2'b00, 2'b00, 1, 0, 0, 1);
        chk("sup_pulses", 32'(pulses), 32'h0);
        chk("sup_grant", 32'(grant), 32'h1);
        chk("sup_ack", 32'(opb_xack), 32'h1); @(negedge clk);
        set_in(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("sup_drop", 32'(grant), 32'h0); @(negedge clk);

        // Retry hands the next arbitration to the other requester
        set_in(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0); @(negedge clk);
        set_in(2'b11, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("rty_grant0", 32'(grant), 32'h1); @(negedge clk);
        set_in(2'b11, 2'b01, 2'b00, 2'b00, 0, 0, 1, 0);
        chk("rty_out", 32'(opb_retry), 32'h1); @(negedge clk);
        set_in(2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("rty_dead", 32'(grant), 32'h0); @(negedge clk);
        set_in(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("rty_next", 32'(grant), 32'h2); @(negedge clk);
        set_in(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0); @(negedge clk);

        // Ack together with retry counts as completion; seqAddr keeps the transfer going
        set_in(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0); @(negedge clk);
        set_in(2'b01, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0); @(negedge clk);
        set_in(2'b01, 2'b01, 2'b00, 2'b01, 1, 0, 1, 0);
        chk("ackrty_ack", 32'(opb_xack), 32'h1); @(negedge clk);
        set_in(2'b00, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0);
        chk("ackrty_grant", 32'(grant), 32'h1);
        chk("ackrty_sel", 32'(opb_select), 32'h1);
        chk("ackrty_seq", 32'(opb_seq), 32'h1); @(negedge clk);
        set_in(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("abort_hold", 32'(grant), 32'h1); @(negedge clk);
        set_in(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("abort_drop", 32'(grant), 32'h0); @(negedge clk);

        // Asynchronous reset in the middle of a transfer
        set_in(2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0); @(negedge clk);
        set_in(2'b11, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("rst_pre_grant", 32'(grant), 32'h2); @(negedge clk);
        set_in(2'b11, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("rst_pre_sel", 32'(opb_select), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_grant", 32'(grant), 32'h0);
        chk("rst_mid_sel", 32'(opb_select), 32'h0);
        chk("rst_mid_abus", opb_abus, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("rst_idle", 32'(grant), 32'h0); @(negedge clk);
        set_in(2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("rst_m0_first", 32'(grant), 32'h1); @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/opb_bus_arbiter.md
Name: opb_bus_arbiter

Overview:
- Round-robin arbiter that shares one OPB segment between NUM_MASTERS masters (PPC bridge plus snapshot/counter-poll engines) and the opb_register_simulink2ppc-style slaves hung on it.
- Grants the bus to one master at a time and muxes that master's address, data and control onto the OPB.
- Broadcasts the slave handshake back to the masters and enforces a bus timeout.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (legal range 2..4).
- TIMEOUT_CYCLES, 16, number of select cycles without an acknowledge before OPB_timeout fires (legal range 4..255).

Ports:
- OPB_Clk  in  1  bus clock; all logic is on the rising edge.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- M_request  in  NUM_MASTERS  per-master bus request.
- M_busLock  in  NUM_MASTERS  per-master lock; holds the grant across transfers.
- M_select  in  NUM_MASTERS  per-master transfer select.
- M_RNW  in  NUM_MASTERS  per-master read-not-write.
- M_seqAddr  in  NUM_MASTERS  per-master sequential-address hint.
- M_ABus  in  32*NUM_MASTERS  concatenated addresses, master 0 in the lowest slice.
- M_BE  in  4*NUM_MASTERS  concatenated byte enables.
- M_DBus  in  32*NUM_MASTERS  concatenated write data.
- OPB_MGrant  out  NUM_MASTERS  registered one-hot grant.
- OPB_ABus  out  32  muxed address; bit 0 is the MSB, as on all OPB buses.
- OPB_BE  out  4  muxed byte enables.
- OPB_DBus  out  32  muxed write data.
- OPB_RNW  out  1  muxed read-not-write.
- OPB_select  out  1  muxed select.
- OPB_seqAddr  out  1  muxed sequential-address hint.
- Sl_DBus  in  32  OR of all slave read data.
- Sl_xferAck  in  1  OR of slave transfer acknowledges.
- Sl_errAck  in  1  OR of slave error acknowledges.
- Sl_retry  in  1  OR of slave retries.
- Sl_toutSup  in  1  OR of slave timeout suppresses.
- OPB_xferAck  out  1  Sl_xferAck gated by the XFER state.
- OPB_errAck  out  1  Sl_errAck gated by the XFER state.
- OPB_retry  out  1  Sl_retry gated by the XFER state.
- OPB_rdDBus  out  32  Sl_DBus when OPB_xferAck is high, else 0.
- OPB_timeout  out  1  one-cycle pulse when a transfer times out.

Behaviour:
- Reset: asynchronous; takes effect immediately, including mid-transfer.
  - State IDLE; OPB_MGrant = 0.
  - All muxed OPB outputs = 0; OPB_timeout = 0; timeout counter = 0.
  - Round-robin pointer last = NUM_MASTERS-1, so master 0 has first priority.
- Mux rule: muxed outputs are the AND-OR of the granted master's slices. Every muxed output is 0 when OPB_MGrant = 0.
- Ack fan-out: OPB_xferAck, OPB_errAck, OPB_retry and OPB_rdDBus are forced to 0 outside XFER. Masters qualify these with their own grant.
- IDLE:
  - If any M_request is high, pick the first requester searching from last+1 with wrap-around.
  - Register its grant and move to GRANT.
  - Latency from request to OPB_MGrant is 1 cycle.
- GRANT (grant held):
  - M_select[g] = 1 -> XFER, counter cleared.
  - M_request[g] = 0 and M_busLock[g] = 0 -> IDLE; grant drops next cycle and last = g.
- XFER: counter increments each cycle that Sl_toutSup = 0, and holds while Sl_toutSup = 1. Event priority, highest first:
  1. Sl_xferAck or Sl_errAck: counter cleared. If M_seqAddr[g] or M_busLock[g] is high, stay in XFER (the next select must be back to back) or go to GRANT if M_select[g] falls. Otherwise go to IDLE and set last = g. A retry or timeout in the same cycle is ignored.
  2. Sl_retry: go to IDLE and set last = g, so another requester wins the next arbitration.
  3. Counter = TIMEOUT_CYCLES-1 with no ack: OPB_timeout = 1 for exactly one cycle, then IDLE with last = g.
  4. M_select[g] falls with no ack (master abort): GRANT if M_busLock[g] is high, else IDLE.
- Grant changes only on the clock edge after leaving GRANT or XFER. A new master is never granted in the same cycle the previous grant drops, which gives one guaranteed dead cycle.
- Counter width is the minimum needed for TIMEOUT_CYCLES-1. It never wraps, because the timeout leaves XFER first.
- M_request bits for non-granted masters are ignored while busy. Requests are level-sensitive: no queuing.

Test Plan:
- Reset released, M_request = 01 -> OPB_MGrant = 01 one cycle later. Select with ABus = 0x01088200 and RNW = 1, slave xferAck on the 3rd cycle with DBus = 0x0000002A -> OPB_rdDBus = 0x0000002A for that cycle, then grant 00 after one dead cycle.
- Both masters request continuously, single transfers -> grants alternate 01, 10, 01, 10; no master is granted twice in a row.
- Master 0 holds busLock over 3 back-to-back transfers while master 1 requests -> master 1 is not granted until after the 3rd ack plus the dead cycle.
- Select held with no ack, toutSup = 0, TIMEOUT_CYCLES = 16 -> OPB_timeout pulses exactly once, on the 16th select cycle; grant drops next cycle. Repeat with toutSup = 1 for 20 cycles and then ack -> no timeout.
- Sl_retry on master 0 while master 1 requests -> next grant = 10. Ack and retry in the same cycle -> treated as a completion.
- OPB_Rst_n pulled low mid-XFER -> OPB_MGrant and OPB_select go to 0 immediately. After release, master 0 wins first.
